uart_wb_arb: RTL

Two-master Wishbone arbiter that shares the single UART register-bank slave port between a host CPU (master 0) and a debug/DMA master (master 1). Round-robin grant, registered slave-side signals, per-transaction ack timeout with error return. Sits directly in front of the UART Wishbone slave interface.

---
 rtl/uart_wb_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_wb_arb.sv
// uart_wb_arb: two-master round-robin Wishbone arbiter in front of the UART
// register-bank slave. Slave-side signals are registered, each transaction
// has an ack timeout, and a RELEASE cycle after each transaction lets the
// slave FSM re-arm.
module uart_wb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  sel;
    } wb_req_t;

    // Last counter value still inside the ack window; reaching it without ack is a timeout.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  last, last_n;     // index of the master served most recently
    logic [1:0]            gnt, gnt_n;
    logic                  act, act_n;       // drives both s_cyc_o and s_stb_o
    wb_req_t               s_req, s_req_n;   // captured request presented to the slave
    logic [1:0]            ack, ack_n;
    logic [1:0]            err, err_n;
    logic [DATA_WIDTH-1:0] m0_dat, m0_dat_n;
    logic [DATA_WIDTH-1:0] m1_dat, m1_dat_n;

    logic    req0, req1, pick, cyc_g;
    wb_req_t m0_req, m1_req;

    assign req0   = m0_cyc_i & m0_stb_i;
    assign req1   = m1_cyc_i & m1_stb_i;
    assign m0_req = '{we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
    assign m1_req = '{we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};

    // Next-state and next-output logic; ack/err default low so they pulse for one cycle.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last;
        gnt_n    = gnt;
        act_n    = act;
        s_req_n  = s_req;
        ack_n    = 2'b00;
        err_n    = 2'b00;
        m0_dat_n = m0_dat;
        m1_dat_n = m1_dat;
        pick     = 1'b0;
        cyc_g    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the master that was not served last wins.
                    pick    = (req0 & req1) ? ~last : req1;
                    gnt_n   = pick ? 2'b10 : 2'b01;
                    s_req_n = pick ? m1_req : m0_req;
                    act_n   = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt + 4'd1;
                pick  = gnt[1];
                cyc_g = pick ? m1_cyc_i : m0_cyc_i;
                if (!cyc_g || s_ack_i || cnt == TMO_LAST) begin
                    act_n   = 1'b0;
                    gnt_n   = 2'b00;
                    last_n  = pick;
                    state_n = RELEASE;
                    // Abort suppresses both ack and err; ack beats a simultaneous timeout.
                    if (cyc_g && s_ack_i) begin
                        ack_n[pick] = 1'b1;
                        if (!s_req.we) begin
                            if (pick) m1_dat_n = s_dat_i;
                            else      m0_dat_n = s_dat_i;
                        end
                    end else if (cyc_g) begin
                        err_n[pick] = 1'b1;
                    end
                end
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset returns everything to idle with master 0 favoured.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            last   <= 1'b1;
            gnt    <= 2'b00;
            act    <= 1'b0;
            s_req  <= '0;
            ack    <= 2'b00;
            err    <= 2'b00;
            m0_dat <= '0;
            m1_dat <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last   <= last_n;
            gnt    <= gnt_n;
            act    <= act_n;
            s_req  <= s_req_n;
            ack    <= ack_n;
            err    <= err_n;
            m0_dat <= m0_dat_n;
            m1_dat <= m1_dat_n;
        end
    end

    assign s_cyc_o  = act;
    assign s_stb_o  = act;
    assign s_we_o   = s_req.we;
    assign s_adr_o  = s_req.adr;
    assign s_dat_o  = s_req.dat;
    assign s_sel_o  = s_req.sel;
    assign gnt_o    = gnt;
    assign m0_ack_o = ack[0];
    assign m1_ack_o = ack[1];
    assign m0_err_o = err[0];
    assign m1_err_o = err[1];
    assign m0_dat_o = m0_dat;
    assign m1_dat_o = m1_dat;

endmodule
